// File: rtl/uart_boot_pkg.sv
// Shared constants and state types for the UART boot loader.
package uart_boot_pkg;

  localparam logic [7:0] SYNC_BYTE        = 8'hA5;
  localparam int         CLKS_PER_BIT_DEF = 87;  // 10 MHz clock, 115200 baud

  // Loader protocol states.
  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } boot_state_t;

  // Serial receiver states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  // The core is held in reset whenever a load is in progress or has failed.
  function automatic logic hold_in(input boot_state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling,
// glitch rejection on the start bit and framing-error reporting.
module uart_rx
  import uart_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    r_sync;
  logic          r_prev;
  rx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_valid;
  logic          r_ferr;
  logic          w_rx;

  assign w_rx         = r_sync[1];
  assign byte_o       = r_byte;
  assign byte_valid_o = r_valid;
  assign frame_err_o  = r_ferr;

  // Synchronise the line, find the start edge and shift in one frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx_i};
      r_prev  <= w_rx;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_prev && !w_rx) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF) begin
            r_cnt <= '0;
            r_bit <= '0;
            // A start bit that has gone high again by mid-bit was noise.
            r_state <= w_rx ? RX_IDLE : RX_BITS;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_BITS: begin
          if (r_cnt == FULL) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= RX_STOP;
            r_bit <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (w_rx) begin
              r_byte  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image and writes it word by
// word into the core's program memory while holding the core in reset.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_i,
  input  logic              uart_rx_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_hold_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  boot_state_t       r_state;
  boot_state_t       w_state_nxt;
  logic              r_core_hold;
  logic              r_done;
  logic              r_err;
  logic [15:0]       r_len;
  logic [15:0]       r_word_cnt;
  logic [15:0]       r_acc_cnt;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_shift;
  logic [7:0]        r_chk;
  logic              r_mem_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic [7:0]        w_byte;
  logic              w_byte_vld;
  logic              w_frame_err;
  logic              w_busy;
  logic              w_abort;
  logic              w_rx_byte;
  logic              w_mem_valid;
  logic              w_accept;
  logic              w_data_byte;
  logic              w_word_done;
  logic              w_overrun;
  logic              w_last_accept;
  logic [15:0]       w_len_nxt;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (uart_rx_i),
    .byte_o      (w_byte),
    .byte_valid_o(w_byte_vld),
    .frame_err_o (w_frame_err)
  );

  // Dropping boot_i mid-load kills any pending write in the same cycle and
  // any byte that lands in that cycle.
  assign w_busy        = (r_state != IDLE) && (r_state != DONE) && (r_state != ERROR);
  assign w_abort       = w_busy && !boot_i;
  assign w_rx_byte     = w_byte_vld && !w_abort;
  assign w_mem_valid   = r_mem_valid && !w_abort;
  assign w_accept      = w_mem_valid && mem_ready_i;
  assign w_data_byte   = (r_state == DATA) && w_rx_byte && (r_word_cnt != r_len);
  assign w_word_done   = w_data_byte && (r_byte_idx == 2'd3);
  // A second word completing before the first is taken, or any byte
  // arriving once all words are in, would otherwise be lost.
  assign w_overrun     = (w_word_done && r_mem_valid && !mem_ready_i) ||
                         ((r_state == DATA) && w_rx_byte && (r_word_cnt == r_len));
  assign w_last_accept = (r_state == DATA) && w_accept && (r_acc_cnt == r_len - 16'd1);
  assign w_len_nxt     = {w_byte, r_len[7:0]};

  assign mem_valid_o = w_mem_valid;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign core_hold_o = r_core_hold;
  assign done_o      = r_done;
  assign err_o       = r_err;

  // Next-state decode for the protocol FSM.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:   if (boot_i) w_state_nxt = SYNC;
        SYNC: begin
          if (w_frame_err)                            w_state_nxt = ERROR;
          else if (w_rx_byte && w_byte == SYNC_BYTE)  w_state_nxt = LEN_LO;
        end
        LEN_LO: begin
          if (w_frame_err)    w_state_nxt = ERROR;
          else if (w_rx_byte) w_state_nxt = LEN_HI;
        end
        LEN_HI: begin
          if (w_frame_err) begin
            w_state_nxt = ERROR;
          end else if (w_rx_byte) begin
            if ({1'b0, w_len_nxt} > MAX_WORDS) w_state_nxt = ERROR;
            else if (w_len_nxt == 16'd0)       w_state_nxt = CHECK;
            else                               w_state_nxt = DATA;
          end
        end
        DATA: begin
          if (w_frame_err || w_overrun) w_state_nxt = ERROR;
          else if (w_last_accept)       w_state_nxt = CHECK;
        end
        CHECK: begin
          if (w_frame_err)    w_state_nxt = ERROR;
          else if (w_rx_byte) w_state_nxt = (w_byte == r_chk) ? DONE : ERROR;
        end
        DONE, ERROR: if (!boot_i) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_core_hold <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_core_hold <= hold_in(w_state_nxt);
      r_done      <= (w_state_nxt == DONE);
      r_err       <= (w_state_nxt == ERROR);
    end
  end

  // Length capture, word assembly, checksum and the one-word write buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_acc_cnt   <= '0;
      r_byte_idx  <= '0;
      r_shift     <= '0;
      r_chk       <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (r_state == IDLE || w_abort) begin
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_acc_cnt   <= '0;
      r_byte_idx  <= '0;
      r_chk       <= '0;
      r_mem_valid <= 1'b0;
    end else begin
      if (r_state == LEN_LO && w_rx_byte) r_len[7:0]  <= w_byte;
      if (r_state == LEN_HI && w_rx_byte) r_len[15:8] <= w_byte;
      if (w_data_byte) begin
        r_chk      <= r_chk ^ w_byte;
        r_byte_idx <= r_byte_idx + 2'd1;
        r_shift    <= {w_byte, r_shift[23:8]};
      end
      if (w_accept) begin
        r_acc_cnt   <= r_acc_cnt + 16'd1;
        r_mem_valid <= 1'b0;
      end
      // Bytes arrive LSB first, so the fourth byte lands on top.
      if (w_word_done) begin
        r_mem_valid <= 1'b1;
        r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
        r_mem_wdata <= {w_byte, r_shift};
        r_word_cnt  <= r_word_cnt + 16'd1;
      end
      if (w_state_nxt == ERROR) r_mem_valid <= 1'b0;
    end
  end

endmodule
